// File: rtl/mpaddsub_pipe.sv
// Multi-precision adder/subtractor: WIDTH-bit operands are processed one LIMB-bit slice
// per clock, least significant first. The (WIDTH+1)-bit result is registered on completion.
module mpaddsub_pipe #(
    parameter int WIDTH = 1027,
    parameter int LIMB  = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             done,
    output logic             busy
);

    localparam int NLIMB = (WIDTH + LIMB) / LIMB;  // ceil((WIDTH+1)/LIMB)
    localparam int TOT   = NLIMB * LIMB;
    localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [TOT-1:0]  a_sr;
    logic [TOT-1:0]  b_sr;
    logic [TOT-1:0]  acc;
    logic [TOT-1:0]  acc_next;
    logic            sub_r;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic [LIMB-1:0] b_limb;
    logic [LIMB:0]   limb_sum;
    logic            accept;

    // Subtract is A + ~B + 1: the B limb is inverted and carry is preloaded with 1.
    always_comb begin
        b_limb   = sub_r ? ~b_sr[LIMB-1:0] : b_sr[LIMB-1:0];
        limb_sum = {1'b0, a_sr[LIMB-1:0]} + {1'b0, b_limb} + {{LIMB{1'b0}}, carry};
        acc_next = (acc >> LIMB) | (TOT'(limb_sum[LIMB-1:0]) << (TOT - LIMB));
    end

    assign accept = start && (state != RUN);

    // NOTE: operand and partial-sum registers carry no reset; every limb is overwritten
    // before it reaches result, and the control state alone decides what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sr  <= TOT'(in_a);
            b_sr  <= TOT'(in_b);
            sub_r <= subtract;
        end else if (state == RUN) begin
            a_sr <= a_sr >> LIMB;
            b_sr <= b_sr >> LIMB;
            acc  <= acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        carry <= subtract;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry <= limb_sum[LIMB];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= acc_next[WIDTH:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
